gpio_in: RTL

GPIO_IN -- requirements
Module: gpio_in

---
 rtl/mrav_pkg.sv | 12 +
 rtl/gpio_in_debounce.sv | 47 ++++
 rtl/gpio_in.sv | 88 ++++++++
 3 files changed

// File: rtl/mrav_pkg.sv
// Shared mrav bus widths and the GPIO input block's register offsets.
package mrav_pkg;

    localparam int MRAV_ADDR_WIDTH = 32;
    localparam int MRAV_DATA_WIDTH = 32;

    localparam logic [1:0] MRAV_GPIO_IN_DATA     = 2'd0;
    localparam logic [1:0] MRAV_GPIO_IN_EDGE     = 2'd1;
    localparam logic [1:0] MRAV_GPIO_IN_IRQ_EN   = 2'd2;
    localparam logic [1:0] MRAV_GPIO_IN_EDGE_SEL = 2'd3;

endpackage

// File: rtl/gpio_in_debounce.sv
// One pin: 2-flop synchronizer followed by a consecutive-mismatch debounce counter.
module gpio_in_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_stable
);

    localparam logic [7:0] LP_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_stable;
    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

    // A single matching sample restarts the count, so only unbroken runs qualify.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= 1'b0;
            r_cnt    <= 8'd0;
        end else if (r_sync2 != r_stable) begin
            if (r_cnt == LP_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end else begin
            r_cnt <= 8'd0;
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/gpio_in.sv
// Eight debounced input pins with latched, direction-selectable edge flags and a level irq.
module gpio_in
    import mrav_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       read,
    input  logic                       write,
    output logic                       read_done,
    output logic                       write_done,
    input  logic [MRAV_ADDR_WIDTH-1:0] addr,
    input  logic [MRAV_DATA_WIDTH-1:0] cpu_data_out,
    output logic [MRAV_DATA_WIDTH-1:0] cpu_data_in,
    input  logic [7:0]                 external_input,
    output logic                       irq
);

    logic [7:0] w_stable;
    logic [7:0] r_stable_prev;
    logic [7:0] r_edge;
    logic [7:0] r_irq_en;
    logic [7:0] r_edge_sel;
    logic       r_irq;
    logic [7:0] w_edge_set;
    logic [7:0] w_edge_clr;
    logic [7:0] w_rd_reg;
    logic [7:0] w_wdata;
    logic       w_unused_bits;

    for (genvar g = 0; g < 8; g++) begin : g_pin
        gpio_in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_pin   (external_input[g]),
            .o_stable(w_stable[g])
        );
    end

    assign w_wdata       = cpu_data_out[7:0];
    assign w_unused_bits = ^{addr[MRAV_ADDR_WIDTH-1:2], cpu_data_out[MRAV_DATA_WIDTH-1:8]};

    // EDGE_SEL bit 1 picks rising transitions of stable, 0 picks falling.
    assign w_edge_set = (r_edge_sel & w_stable & ~r_stable_prev) |
                        (~r_edge_sel & ~w_stable & r_stable_prev);
    assign w_edge_clr = (write && addr[1:0] == MRAV_GPIO_IN_EDGE) ? w_wdata : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable_prev <= 8'h00;
            r_edge        <= 8'h00;
            r_irq_en      <= 8'h00;
            r_edge_sel    <= 8'h00;
            r_irq         <= 1'b0;
        end else begin
            r_stable_prev <= w_stable;
            // A new edge outranks a simultaneous write-1-to-clear of the same bit.
            r_edge        <= (r_edge & ~w_edge_clr) | w_edge_set;
            r_irq         <= |(r_edge & r_irq_en);
            if (write && addr[1:0] == MRAV_GPIO_IN_IRQ_EN) begin
                r_irq_en <= w_wdata;
            end
            if (write && addr[1:0] == MRAV_GPIO_IN_EDGE_SEL) begin
                r_edge_sel <= w_wdata;
            end
        end
    end

    always_comb begin
        w_rd_reg = 8'h00;
        case (addr[1:0])
            MRAV_GPIO_IN_DATA:     w_rd_reg = w_stable;
            MRAV_GPIO_IN_EDGE:     w_rd_reg = r_edge;
            MRAV_GPIO_IN_IRQ_EN:   w_rd_reg = r_irq_en;
            MRAV_GPIO_IN_EDGE_SEL: w_rd_reg = r_edge_sel;
            default:               w_rd_reg = 8'h00;
        endcase
    end

    assign cpu_data_in = read ? {{(MRAV_DATA_WIDTH-8){1'b0}}, w_rd_reg} : '0;
    assign read_done   = read;
    assign write_done  = write;
    assign irq         = r_irq;

endmodule
